// File: rtl/store_datapath_if.sv
// Store request and data-memory write bundle shared by the store datapath and its neighbours.
// The slave modport is the store datapath's view; master is the execute/memory side.
interface store_datapath_if;
  logic        st_valid;
  logic        st_ready;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;

  modport slave (
    input  st_valid, st_funct3, st_addr, st_data, mem_ack,
    output st_ready, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output st_valid, st_funct3, st_addr, st_data, mem_ack,
    input  st_ready, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/store_datapath.sv
// Store datapath: lane-replicates SB/SH/SW data, builds byte strobes and drains an in-order store buffer.
// Optional misaligned-store trap is enabled by defining STORE_MISALIGN_TRAP_EN.
module store_datapath #(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  store_datapath_if.slave   bus,
  output logic              sb_empty,
  output logic              misaligned,
  output logic [31:0]       misaligned_addr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  // Handshakes: a store is taken on a rising edge with st_valid && st_ready;
  // the buffer head retires on a rising edge with mem_we && mem_ack.
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [31:0]   r_addr_mem  [DEPTH];
  logic [31:0]   r_wdata_mem [DEPTH];
  logic [3:0]    r_wstrb_mem [DEPTH];

  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_retire;
  logic        w_enq;
  logic        w_legal;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;

  assign w_full       = (r_count == FULL_CNT);
  assign w_empty      = (r_count == '0);
  assign bus.st_ready = !w_full && rst_n;
  assign w_accept     = bus.st_valid && bus.st_ready;
  assign w_retire     = !w_empty && bus.mem_ack;
  assign sb_empty     = w_empty;

  // SH/SW strobes are built from the upper address bits only, which force-aligns them.
  always_comb begin
    w_legal = 1'b1;
    w_addr  = {bus.st_addr[31:2], 2'b00};
    w_wdata = bus.st_data;
    w_wstrb = 4'b1111;
    case (bus.st_funct3)
      3'b000: begin
        w_wdata = {4{bus.st_data[7:0]}};
        w_wstrb = 4'b0001 << bus.st_addr[1:0];
      end
      3'b001: begin
        w_wdata = {2{bus.st_data[15:0]}};
        w_wstrb = 4'b0011 << {bus.st_addr[1], 1'b0};
      end
      3'b010: begin
        w_wdata = bus.st_data;
        w_wstrb = 4'b1111;
      end
      default: w_legal = 1'b0;
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic        w_mis;
  logic        r_mis;
  logic [31:0] r_mis_addr;

  assign w_mis = ((bus.st_funct3 == 3'b001) && bus.st_addr[0]) ||
                 ((bus.st_funct3 == 3'b010) && (bus.st_addr[1:0] != 2'b00));
  assign w_enq = w_accept && w_legal && !w_mis;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mis      <= 1'b0;
      r_mis_addr <= '0;
    end else begin
      r_mis <= w_accept && w_legal && w_mis;
      if (w_accept && w_legal && w_mis) r_mis_addr <= bus.st_addr;
    end
  end

  assign misaligned      = r_mis;
  assign misaligned_addr = r_mis_addr;
`else
  assign w_enq           = w_accept && w_legal;
  assign misaligned      = 1'b0;
  assign misaligned_addr = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq)    r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_retire) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_enq && !w_retire)      r_count <= r_count + 1'b1;
      else if (!w_enq && w_retire) r_count <= r_count - 1'b1;
    end
  end

  // Entry storage needs no reset: the outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr_mem[r_wr_ptr]  <= w_addr;
      r_wdata_mem[r_wr_ptr] <= w_wdata;
      r_wstrb_mem[r_wr_ptr] <= w_wstrb;
    end
  end

  assign bus.mem_we    = !w_empty;
  assign bus.mem_addr  = w_empty ? '0 : r_addr_mem[r_rd_ptr];
  assign bus.mem_wdata = w_empty ? '0 : r_wdata_mem[r_rd_ptr];
  assign bus.mem_wstrb = w_empty ? '0 : r_wstrb_mem[r_rd_ptr];
endmodule

// File: tb/tb_store_datapath.sv
// Bench for store_datapath: directed vector table, hand sequences for backpressure/throughput/reset,
// then random traffic against a queue-based reference model.
module tb_store_datapath;
  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        sb_empty;
  logic        misaligned;
  logic [31:0] misaligned_addr;

  store_datapath_if bus();

  store_datapath #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .sb_empty        (sb_empty),
    .misaligned      (misaligned),
    .misaligned_addr (misaligned_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  `ifdef STORE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
  `else
  localparam bit TRAP = 1'b0;
  `endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        mis;
  } vec_t;

  vec_t vecs[11];

  // Reference model: packed {addr, wdata, wstrb} entries in acceptance order.
  logic [67:0] exp_q[$];

  function automatic logic [67:0] model_entry(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] d);
    logic [31:0] wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    int lane;
    wa = a - (a % 4);
    lane = int'(a % 4);
    if (f3 == 3'd0) begin
      wd = (d % 256) * 32'h0101_0101;
      ws = 4'(1 << lane);
    end else if (f3 == 3'd1) begin
      wd = (d % 65536) * 32'h0001_0001;
      ws = 4'(3 << ((lane / 2) * 2));
    end else begin
      wd = d;
      ws = 4'd15;
    end
    return {wa, wd, ws};
  endfunction

  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] a);
    return (f3 == 3'd1 && (a % 2) != 0) || (f3 == 3'd2 && (a % 4) != 0);
  endfunction

  task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic ack);
    bus.st_valid  = v;
    bus.st_funct3 = f3;
    bus.st_addr   = a;
    bus.st_data   = d;
    bus.mem_ack   = ack;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    drive(1'b1, v.f3, v.addr, v.data, 1'b1);
    #1 check({tag, "_ready"}, 32'(bus.st_ready), 32'd1);
    @(posedge clk);
    #1 bus.st_valid = 1'b0;
    check({tag, "_we"},    32'(bus.mem_we), 32'(v.we));
    check({tag, "_addr"},  bus.mem_addr, v.maddr);
    check({tag, "_wdata"}, bus.mem_wdata, v.wdata);
    check({tag, "_wstrb"}, 32'(bus.mem_wstrb), 32'(v.wstrb));
    check({tag, "_mis"},   32'(misaligned), 32'(v.mis));
    if (v.mis) check({tag, "_misaddr"}, misaligned_addr, v.addr);
    if (!TRAP) check({tag, "_misaddr0"}, misaligned_addr, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_empty"},   32'(sb_empty), 32'd1);
    check({tag, "_mis_end"}, 32'(misaligned), 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic        v;
    logic        ack;
    logic        exp_mis;
    logic [31:0] exp_mis_addr;
    logic [67:0] head;
    bit          accept;
    int          r;

    vecs[0]  = '{3'b000, 32'h100, 32'h0000_00A5, 1'b1, 32'h100, 32'hA5A5_A5A5, 4'b0001, 1'b0};
    vecs[1]  = '{3'b000, 32'h101, 32'h0000_00A5, 1'b1, 32'h100, 32'hA5A5_A5A5, 4'b0010, 1'b0};
    vecs[2]  = '{3'b000, 32'h102, 32'h0000_00A5, 1'b1, 32'h100, 32'hA5A5_A5A5, 4'b0100, 1'b0};
    vecs[3]  = '{3'b000, 32'h103, 32'h0000_00A5, 1'b1, 32'h100, 32'hA5A5_A5A5, 4'b1000, 1'b0};
    vecs[4]  = '{3'b001, 32'h202, 32'hABCD_1234, 1'b1, 32'h200, 32'h1234_1234, 4'b1100, 1'b0};
    vecs[5]  = '{3'b001, 32'h200, 32'h0000_5678, 1'b1, 32'h200, 32'h5678_5678, 4'b0011, 1'b0};
    vecs[6]  = '{3'b010, 32'h300, 32'hDEAD_BEEF, 1'b1, 32'h300, 32'hDEAD_BEEF, 4'b1111, 1'b0};
    vecs[7]  = '{3'b011, 32'h500, 32'h1111_2222, 1'b0, 32'h0,   32'h0,         4'b0000, 1'b0};
    vecs[8]  = '{3'b111, 32'h504, 32'h3333_4444, 1'b0, 32'h0,   32'h0,         4'b0000, 1'b0};
    if (TRAP) begin
      vecs[9]  = '{3'b010, 32'h405, 32'h1122_3344, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1};
      vecs[10] = '{3'b001, 32'h603, 32'h0000_BEEF, 1'b0, 32'h0, 32'h0, 4'b0000, 1'b1};
    end else begin
      vecs[9]  = '{3'b010, 32'h405, 32'h1122_3344, 1'b1, 32'h404, 32'h1122_3344, 4'b1111, 1'b0};
      vecs[10] = '{3'b001, 32'h603, 32'h0000_BEEF, 1'b1, 32'h600, 32'hBEEF_BEEF, 4'b1100, 1'b0};
    end

    // Reset
    rst_n = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.st_ready), 32'd0);
    check("rst_we",    32'(bus.mem_we), 32'd0);
    check("rst_addr",  bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
    check("rst_empty", 32'(sb_empty), 32'd1);
    check("rst_mis",   32'(misaligned), 32'd0);
    check("rst_misaddr", misaligned_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) apply_vec(vecs[i], i);

    // Backpressure: three SWs with mem_ack low, third stalls until the first retire.
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h1000, 32'hAAAA_0000, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h1004, 32'hAAAA_0001, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h1008, 32'hAAAA_0002, 1'b0);
    #1 check("bp_full_ready", 32'(bus.st_ready), 32'd0);
    check("bp_head0", bus.mem_addr, 32'h1000);
    @(negedge clk);
    bus.mem_ack = 1'b1;
    #1 check("bp_ready_on_retire", 32'(bus.st_ready), 32'd0);
    check("bp_wdata0", bus.mem_wdata, 32'hAAAA_0000);
    @(negedge clk);
    #1 check("bp_ready_back", 32'(bus.st_ready), 32'd1);
    check("bp_head1", bus.mem_addr, 32'h1004);
    check("bp_wdata1", bus.mem_wdata, 32'hAAAA_0001);
    @(negedge clk);
    bus.st_valid = 1'b0;
    #1 check("bp_head2", bus.mem_addr, 32'h1008);
    check("bp_wdata2", bus.mem_wdata, 32'hAAAA_0002);
    @(negedge clk);
    #1 check("bp_drained", 32'(sb_empty), 32'd1);

    // Throughput: one store per cycle with mem_ack held high.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 3'b010, 32'h2000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b1);
      #1 check($sformatf("tp%0d_ready", i), 32'(bus.st_ready), 32'd1);
      check($sformatf("tp%0d_we", i), 32'(bus.mem_we), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) check($sformatf("tp%0d_addr", i), bus.mem_addr, 32'h2000 + 32'(4 * (i - 1)));
    end
    @(negedge clk);
    bus.st_valid = 1'b0;
    #1 check("tp_last", bus.mem_addr, 32'h200C);
    @(negedge clk);
    #1 check("tp_empty", 32'(sb_empty), 32'd1);

    // Reset with two buffered stores: everything discarded.
    @(negedge clk);
    drive(1'b1, 3'b010, 32'h3000, 32'h1, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'b000, 32'h3005, 32'h2, 1'b0);
    @(negedge clk);
    bus.st_valid = 1'b0;
    #1 check("mr_full", 32'(sb_empty), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("mr_ready_low", 32'(bus.st_ready), 32'd0);
    @(posedge clk);
    #1;
    check("mr_we",    32'(bus.mem_we), 32'd0);
    check("mr_empty", 32'(sb_empty), 32'd1);
    check("mr_addr",  bus.mem_addr, 32'd0);
    check("mr_misaddr", misaligned_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 check($sformatf("mr_idle%0d", i), 32'(bus.mem_we), 32'd0);
    end

    // Random traffic against the queue model.
    exp_q.delete();
    exp_mis = 1'b0;
    exp_mis_addr = 32'd0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      v = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 9));
      if (r < 3)      f3 = 3'd0;
      else if (r < 6) f3 = 3'd1;
      else if (r < 9) f3 = 3'd2;
      else            f3 = 3'($urandom_range(3, 7));
      a = $urandom;
      d = $urandom;
      ack = (cyc < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive(v, f3, a, d, ack);
      #1;
      check("rnd_ready", 32'(bus.st_ready), (exp_q.size() < DEPTH) ? 32'd1 : 32'd0);
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        check("rnd_we",    32'(bus.mem_we), 32'd1);
        check("rnd_addr",  bus.mem_addr, head[67:36]);
        check("rnd_wdata", bus.mem_wdata, head[35:4]);
        check("rnd_wstrb", 32'(bus.mem_wstrb), 32'(head[3:0]));
      end else begin
        check("rnd_we_idle",   32'(bus.mem_we), 32'd0);
        check("rnd_addr_idle", bus.mem_addr | bus.mem_wdata | 32'(bus.mem_wstrb), 32'd0);
      end
      check("rnd_empty",   32'(sb_empty), (exp_q.size() == 0) ? 32'd1 : 32'd0);
      check("rnd_mis",     32'(misaligned), 32'(exp_mis));
      check("rnd_misaddr", misaligned_addr, exp_mis_addr);

      accept = v && (exp_q.size() < DEPTH);
      if (exp_q.size() > 0 && ack) void'(exp_q.pop_front());
      exp_mis = 1'b0;
      if (accept && f3 <= 3'd2) begin
        if (TRAP && model_mis(f3, a)) begin
          exp_mis = 1'b1;
          exp_mis_addr = a;
        end else begin
          exp_q.push_back(model_entry(f3, a, d));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/store_datapath.md
# store_datapath

Store-side datapath between the execute stage and the data-memory write port. It accepts store requests (funct3, byte address, rs2 value) over a valid/ready handshake and converts each one into a word-aligned address, lane-replicated write data and a 4-bit byte strobe. Accepted stores are held in a small in-order store buffer and drained to memory over a request/acknowledge handshake. It is the write-direction counterpart of the load byte/half extraction path.

## Interface
- `DEPTH`, 2: store-buffer entries; power of two, ≥2.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `st_valid` in 1: store request valid.
- `st_ready` out 1: buffer can accept a request.
- `st_funct3` in 3: 000=SB, 001=SH, 010=SW; other codes are illegal.
- `st_addr` in 32: byte address from the ALU.
- `st_data` in 32: rs2 value.
- `mem_we` out 1: write request valid (buffer head present).
- `mem_addr` out 32: word address, `{st_addr[31:2],2'b00}`.
- `mem_wdata` out 32: lane-aligned write data.
- `mem_wstrb` out 4: byte enables; bit i enables `mem_wdata[8i+7:8i]`.
- `mem_ack` in 1: memory accepts the head entry this cycle.
- `sb_empty` out 1: buffer holds no entries.
- `misaligned` out 1: one-cycle trap pulse (only with the configuration macro).
- `misaligned_addr` out 32: byte address of the last misaligned store.

## Operation
- **Handshake:** a request is accepted on a rising edge with `st_valid && st_ready`. `st_ready = !full && rst_n`.
- **SB:** wdata `{4{st_data[7:0]}}`; wstrb `4'b0001 << st_addr[1:0]`.
- **SH:** wdata `{2{st_data[15:0]}}`; wstrb `4'b0011 << {st_addr[1],1'b0}`.
- **SW:** wdata `st_data`; wstrb `4'b1111`.
- **Illegal funct3:** the request is accepted and consumed but not enqueued. No trap, no memory write.
- **Store buffer:** circular FIFO with read/write pointers of width log2(DEPTH) that wrap modulo DEPTH, and an occupancy counter 0..DEPTH. `full` is count==DEPTH; `sb_empty` is count==0.
- **Drain:** the head entry drives `mem_addr`/`mem_wdata`/`mem_wstrb`, and `mem_we = !sb_empty`. The head retires on `mem_we && mem_ack`. Stores drain strictly in acceptance order.
- **Idle outputs:** when the buffer is empty, `mem_addr`, `mem_wdata` and `mem_wstrb` are all zero.
- **Enqueue and retire together:** when both happen in the same cycle, the count is unchanged and both pointers advance.
- **Full buffer:** `st_ready` is 0, including in a cycle where `mem_ack` retires the head. There is no same-cycle bypass, so a freed slot is reusable from the next cycle.
- **`mem_ack` while `mem_we` = 0:** ignored.

## Timing
- **Reset** (`rst_n` low at an edge): pointers and count go to 0. Outputs: `mem_we` 0, `mem_addr`/`mem_wdata`/`mem_wstrb` 0, `sb_empty` 1, `misaligned` 0, `misaligned_addr` 0. `st_ready` is 0 while `rst_n` is low.
- **Reset mid-operation:** all buffered stores are discarded; no partial write is presented after the reset edge.
- **Latency:** a store accepted at edge N into an empty buffer gives `mem_we` = 1 in cycle N+1. With `mem_ack` held at 1, one entry retires per cycle.
- **Throughput:** with `mem_ack` held at 1 the block sustains one store per cycle.
- **`misaligned`:** when asserted, rises in the cycle after acceptance and lasts exactly one cycle. `misaligned_addr` updates on the same edge.

## Configuration
- **`STORE_MISALIGN_TRAP_EN` defined:**
  - A misaligned store (SH with `st_addr[0]=1`, or SW with `st_addr[1:0]!=0`) is accepted but not enqueued.
  - `misaligned` pulses and `misaligned_addr` captures `st_addr`.
- **`STORE_MISALIGN_TRAP_EN` undefined:**
  - Low address bits are force-aligned: SH ignores `st_addr[0]`; SW ignores `st_addr[1:0]`.
  - The store is enqueued normally.
  - `misaligned` and `misaligned_addr` are tied to 0.

## Test plan
- **SB lanes:** SB with `st_data=32'h000000A5`, `st_addr` 0x100..0x103, `mem_ack`=1 → `mem_addr`=0x100 each time, `mem_wdata`=0xA5A5A5A5, wstrb 0001/0010/0100/1000 in order, each one cycle after acceptance.
- **SH / SW:** SH `st_data=32'hXXXX1234` at 0x202 → wdata 0x12341234, wstrb 1100, `mem_addr` 0x200. SW 0xDEADBEEF at 0x300 → wstrb 1111.
- **Backpressure:** DEPTH=2, `mem_ack`=0, three back-to-back requests → third stalls with `st_ready`=0. Raising `mem_ack` drains in order, and `st_ready` returns the cycle after the first retire.
- **Misaligned (macro defined):** SW at 0x405 → no `mem_we`, `misaligned` pulse one cycle, `misaligned_addr`=0x405. Without the macro → write to 0x404 with wstrb 1111.
- **Illegal funct3 and reset:** funct3=011 → accepted, no write. Two stores buffered with `mem_ack`=0, then `rst_n` low one cycle → `mem_we` 0, `sb_empty` 1, nothing written afterwards.
